spike_arbiter: RTL and testbench

Round-robin arbiter that shares one spike-event output channel between N free-running oscillator neurons. Each neuron's one-cycle spike pulse is captured in a per-neuron pending bit. Pending spikes are then serialised onto a single valid/ready event port as neuron indices. The block sits between the neuron array and the downstream spike consumer (output pins or coupling logic), and counts spikes lost to backpressure.

---
 rtl/spike_pkg.sv | 14 +
 rtl/spike_arbiter_rr_pick.sv | 29 ++
 rtl/spike_arbiter.sv | 101 ++++++++++
 tb/tb_spike_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/spike_pkg.sv
// Shared defaults and width helper for the spike event path (neuron array and arbiter).
// No logic: constants and a compile-time function only.
// No flow control.
package spike_pkg;

    localparam int SPK_N    = 8;
    localparam int SPK_CNTW = 8;

    // Event-index width for n neurons; never below one bit.
    function automatic int spk_idw(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spike_arbiter_rr_pick.sv
// Rotating find-first: first set req bit searching ptr+1, ptr+2, ... modulo N.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is used.
// Ports: req (request vector), ptr (last granted index), gnt_valid (any request), gnt_id (winner).
module rr_pick #(
    parameter int N   = 8,
    parameter int IDW = 3
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           gnt_valid,
    output logic [IDW-1:0] gnt_id
);

    always_comb begin
        int w_idx;
        w_idx     = 0;
        gnt_valid = 1'b0;
        gnt_id    = '0;
        for (int k = 1; k <= N; k++) begin
            w_idx = (int'(ptr) + k) % N;
            if (!gnt_valid && req[w_idx]) begin
                gnt_valid = 1'b1;
                gnt_id    = IDW'(w_idx);
            end
        end
    end

endmodule

// File: rtl/spike_arbiter.sv
// Serialises per-neuron spike pulses onto one valid/ready event port as neuron indices.
// Latency: spike in cycle t appears on ev_valid/ev_id after edge t+1 at best (2 cycles).
// Backpressure: event held stable while ev_ready=0; spikes hitting a set pending bit are counted as drops.
// Ports: clk, rst_n (sync, active low); spike_in/en per neuron; ev_valid/ev_id/ev_ready event port;
//        pending (debug view of captured spikes); drop_cnt (saturating lost-spike counter).
module spike_arbiter
    import spike_pkg::*;
#(
    parameter int N    = SPK_N,
    parameter int IDW  = spk_idw(N),
    parameter int CNTW = SPK_CNTW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    spike_in,
    input  logic [N-1:0]    en,
    input  logic            ev_ready,
    output logic            ev_valid,
    output logic [IDW-1:0]  ev_id,
    output logic [N-1:0]    pending,
    output logic [CNTW-1:0] drop_cnt
);

    localparam int PCW   = $clog2(N + 1);
    localparam int SUMW  = CNTW + PCW;
    localparam logic [SUMW-1:0] CNT_MAX = {{PCW{1'b0}}, {CNTW{1'b1}}};

    logic [N-1:0]    r_pending;
    logic [IDW-1:0]  r_ptr;
    logic            r_valid;
    logic [IDW-1:0]  r_id;
    logic [CNTW-1:0] r_drop;

    logic            w_load_ok;
    logic            w_gnt_vld;
    logic [IDW-1:0]  w_gnt_id;
    logic            w_grant;
    logic [N-1:0]    w_gnt_oh;
    logic [N-1:0]    w_cap;
    logic [N-1:0]    w_drop;
    logic [N-1:0]    w_pending_nxt;
    logic [PCW-1:0]  w_drop_num;
    logic [SUMW-1:0] w_drop_sum;

    // Output register can take a new event when empty or being drained this cycle.
    assign w_load_ok = !r_valid || ev_ready;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req       (r_pending & en),
        .ptr       (r_ptr),
        .gnt_valid (w_gnt_vld),
        .gnt_id    (w_gnt_id)
    );

    assign w_grant  = w_load_ok && w_gnt_vld;
    assign w_gnt_oh = w_grant ? ({{(N-1){1'b0}}, 1'b1} << w_gnt_id) : '0;
    assign w_cap    = spike_in & en;
    // A spike on the index being granted simply re-arms its bit, so it is not lost.
    assign w_drop   = w_cap & r_pending & ~w_gnt_oh;

    // Disable wins, then a fresh capture, then the grant clears the bit.
    assign w_pending_nxt = en & (w_cap | (r_pending & ~w_gnt_oh));

    always_comb begin
        w_drop_num = '0;
        for (int i = 0; i < N; i++) begin
            w_drop_num = w_drop_num + PCW'(w_drop[i]);
        end
    end

    assign w_drop_sum = {{PCW{1'b0}}, r_drop} + {{CNTW{1'b0}}, w_drop_num};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_ptr     <= IDW'(N - 1);
            r_valid   <= 1'b0;
            r_id      <= '0;
            r_drop    <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            r_drop    <= (w_drop_sum > CNT_MAX) ? {CNTW{1'b1}} : w_drop_sum[CNTW-1:0];
            if (w_load_ok) begin
                r_valid <= w_gnt_vld;
                if (w_gnt_vld) begin
                    r_id  <= w_gnt_id;
                    r_ptr <= w_gnt_id;
                end
            end
        end
    end

    assign ev_valid = r_valid;
    assign ev_id    = r_id;
    assign pending  = r_pending;
    assign drop_cnt = r_drop;

endmodule

// File: tb/tb_spike_arbiter.sv
// Bench for spike_arbiter: directed scenarios plus random traffic against a behavioural model.
// A second instance with a 2-bit drop counter shares the stimulus to exercise saturation.
// Model is stepped once per clock edge; DUT outputs are sampled 1ns after the edge.
module tb_spike_arbiter;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] spike_in;
    logic [7:0] en;
    logic       ev_ready;

    logic       ev_valid,  ev_valid2;
    logic [2:0] ev_id,     ev_id2;
    logic [7:0] pending,   pending2;
    logic [7:0] drop_cnt;
    logic [1:0] drop_cnt2;

    int n_cmp = 0;
    int n_bad = 0;

    // behavioural reference state
    bit [7:0] m_pend;
    int       m_ptr;
    bit       m_vld;
    int       m_id;
    int       m_drops;

    always #5 clk = ~clk;

    spike_arbiter #(.N(8), .CNTW(8)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .spike_in (spike_in),
        .en       (en),
        .ev_ready (ev_ready),
        .ev_valid (ev_valid),
        .ev_id    (ev_id),
        .pending  (pending),
        .drop_cnt (drop_cnt)
    );

    spike_arbiter #(.N(8), .CNTW(2)) u_dut_sat (
        .clk      (clk),
        .rst_n    (rst_n),
        .spike_in (spike_in),
        .en       (en),
        .ev_ready (ev_ready),
        .ev_valid (ev_valid2),
        .ev_id    (ev_id2),
        .pending  (pending2),
        .drop_cnt (drop_cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock of the arbiter's rules, applied to the model.
    task automatic model_step(input bit [7:0] sp, input bit [7:0] e, input bit rdy, input bit rst);
        int       g;
        int       d;
        bit       free;
        bit [7:0] nxt;
        if (!rst) begin
            m_pend = '0; m_vld = 0; m_id = 0; m_drops = 0; m_ptr = N - 1;
            return;
        end
        free = !m_vld || rdy;
        g = -1;
        if (free) begin
            for (int k = 1; k <= N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (g < 0 && m_pend[j] && e[j]) g = j;
            end
        end
        d = 0;
        for (int i = 0; i < N; i++) begin
            if (sp[i] && e[i] && m_pend[i] && i != g) d++;
            if (!e[i])      nxt[i] = 1'b0;
            else if (sp[i]) nxt[i] = 1'b1;
            else if (i == g) nxt[i] = 1'b0;
            else            nxt[i] = m_pend[i];
        end
        m_pend = nxt;
        m_drops += d;
        if (free) begin
            if (g >= 0) begin m_vld = 1; m_id = g; m_ptr = g; end
            else m_vld = 0;
        end
    endtask

    task automatic cyc(input logic [7:0] sp, input logic [7:0] e, input logic rdy, input logic rst);
        spike_in = sp; en = e; ev_ready = rdy; rst_n = rst;
        @(posedge clk);
        model_step(sp, e, rdy, rst);
        #1;
        chk("valid", {31'd0, ev_valid}, {31'd0, m_vld});
        if (m_vld) chk("id", {29'd0, ev_id}, m_id);
        chk("pending", {24'd0, pending}, {24'd0, m_pend});
        chk("drop", {24'd0, drop_cnt}, (m_drops > 255) ? 255 : m_drops);
        chk("valid_sat", {31'd0, ev_valid2}, {31'd0, m_vld});
        chk("pending_sat", {24'd0, pending2}, {24'd0, m_pend});
        chk("drop_sat", {30'd0, drop_cnt2}, (m_drops > 3) ? 3 : m_drops);
    endtask

    initial begin
        spike_in = '0; en = 8'hFF; ev_ready = 1'b0; rst_n = 1'b0;

        // reset with spikes active
        cyc(8'hFF, 8'hFF, 1'b1, 1'b0);
        cyc(8'hFF, 8'hFF, 1'b1, 1'b0);
        chk("rst_valid", {31'd0, ev_valid}, 0);
        chk("rst_pending", {24'd0, pending}, 0);
        chk("rst_drop", {24'd0, drop_cnt}, 0);
        cyc(8'h01, 8'hFF, 1'b1, 1'b1);
        cyc(8'h00, 8'hFF, 1'b1, 1'b1);
        chk("lat2_valid", {31'd0, ev_valid}, 1);
        chk("lat2_id", {29'd0, ev_id}, 0);

        // fairness from a fresh reset
        cyc(8'h00, 8'hFF, 1'b1, 1'b0);
        cyc(8'hFF, 8'hFF, 1'b1, 1'b1);
        for (int k = 0; k < 8; k++) begin
            cyc(8'h00, 8'hFF, 1'b1, 1'b1);
            chk("fair_valid", {31'd0, ev_valid}, 1);
            chk("fair_id", {29'd0, ev_id}, k);
        end
        cyc(8'h00, 8'hFF, 1'b1, 1'b1);
        chk("fair_idle", {31'd0, ev_valid}, 0);

        // wrap-around after granting 5
        cyc(8'h20, 8'hFF, 1'b1, 1'b1);
        cyc(8'h00, 8'hFF, 1'b1, 1'b1);
        chk("wrap_id5", {29'd0, ev_id}, 5);
        cyc(8'h44, 8'hFF, 1'b1, 1'b1);
        cyc(8'h00, 8'hFF, 1'b1, 1'b1);
        chk("wrap_first", {29'd0, ev_id}, 6);
        cyc(8'h00, 8'hFF, 1'b1, 1'b1);
        chk("wrap_second", {29'd0, ev_id}, 2);
        cyc(8'h00, 8'hFF, 1'b1, 1'b1);

        // backpressure: three spikes on 3 while stalled
        cyc(8'h08, 8'hFF, 1'b0, 1'b1);
        cyc(8'h00, 8'hFF, 1'b0, 1'b1);
        cyc(8'h08, 8'hFF, 1'b0, 1'b1);
        cyc(8'h00, 8'hFF, 1'b0, 1'b1);
        cyc(8'h08, 8'hFF, 1'b0, 1'b1);
        chk("bp_valid", {31'd0, ev_valid}, 1);
        chk("bp_id", {29'd0, ev_id}, 3);
        chk("bp_pend3", {31'd0, pending[3]}, 1);
        chk("bp_drop", {24'd0, drop_cnt}, 1);
        cyc(8'h00, 8'hFF, 1'b1, 1'b1);
        chk("bp_rel_id", {29'd0, ev_id}, 3);
        chk("bp_rel_valid", {31'd0, ev_valid}, 1);
        cyc(8'h00, 8'hFF, 1'b1, 1'b1);
        chk("bp_idle", {31'd0, ev_valid}, 0);

        // saturation: many simultaneous drops while stalled
        cyc(8'hFF, 8'hFF, 1'b0, 1'b1);
        cyc(8'hFF, 8'hFF, 1'b0, 1'b1);
        cyc(8'hFF, 8'hFF, 1'b0, 1'b1);
        chk("sat_small", {30'd0, drop_cnt2}, 3);

        // disable clears pending without a drop
        cyc(8'h00, 8'hFF, 1'b0, 1'b0);
        cyc(8'h04, 8'hFF, 1'b0, 1'b1);
        cyc(8'h00, 8'hFF, 1'b0, 1'b1);
        cyc(8'h10, 8'hFF, 1'b0, 1'b1);
        chk("en_pend4_set", {31'd0, pending[4]}, 1);
        cyc(8'h00, 8'hEF, 1'b0, 1'b1);
        chk("en_pend4_clr", {31'd0, pending[4]}, 0);
        chk("en_drop", {24'd0, drop_cnt}, 0);

        // spike on the index being granted re-arms it
        cyc(8'h00, 8'hFF, 1'b1, 1'b0);
        cyc(8'h02, 8'hFF, 1'b1, 1'b1);
        cyc(8'h02, 8'hFF, 1'b1, 1'b1);
        chk("sim_id", {29'd0, ev_id}, 1);
        chk("sim_pend1", {31'd0, pending[1]}, 1);
        chk("sim_drop", {24'd0, drop_cnt}, 0);

        // random traffic
        for (int t = 0; t < 3000; t++) begin
            logic [7:0] sp, e;
            logic       rdy, rst;
            sp  = 8'($urandom) & 8'($urandom);
            e   = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'hFF;
            rdy = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 299) != 0);
            cyc(sp, e, rdy, rst);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
